// File: rtl/sw_code_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sw_code_gen                                                  |
// | Description : Source stage for the 3-8 LED decoder. Synchronises and       |
// |               debounces four switches and an active-low push-key, then     |
// |               drives a 3-bit code. Manual mode follows SW[2:0]. Auto mode  |
// |               is a running light that steps every STEP_CNT cycles. The key |
// |               reverses the stepping direction.                             |
// | Ports       : CLK  - system clock, all state on rising edge                |
// |               RST  - asynchronous active-high reset                        |
// |               SW   - raw switches, [2:0] manual code, [3] mode (1 = auto)  |
// |               KEY  - raw push-key, active-low                              |
// |               CODE - registered code to the decoder                        |
// |               DIR  - auto direction, 0 = up, 1 = down                      |
// |               STEP - one-cycle pulse on every auto-mode code change        |
// |               AUTO - high while in auto mode                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sw_code_gen #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int STEP_CNT = 25_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW,
  input  logic       KEY,
  output logic [2:0] CODE,
  output logic       DIR,
  output logic       STEP,
  output logic       AUTO
);

  localparam int c_DEB_W  = (DEB_CNT  > 1) ? $clog2(DEB_CNT)  : 1;
  localparam int c_STEP_W = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CNT - 1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CNT - 1);
  // Bit 4 is the key (idle high), bits 3:0 are the switches (idle low).
  localparam logic [4:0] c_IN_RST = 5'b10000;

  typedef enum logic [0:0] {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  logic [4:0]          w_raw;
  logic [4:0]          r_s1;
  logic [4:0]          r_s2;
  logic [4:0]          w_deb;
  logic                r_key_q;
  logic                w_kpress;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_code;
  logic [2:0]          w_code_nxt;
  logic                r_dir;
  logic                w_dir_nxt;
  logic                r_step;
  logic                w_step_nxt;
  logic [c_STEP_W-1:0] r_timer;
  logic [c_STEP_W-1:0] w_timer_nxt;

  assign w_raw = {KEY, SW};

  // Two-flop synchroniser for all five raw inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1 <= c_IN_RST;
      r_s2 <= c_IN_RST;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Independent debouncer per input: the new level is accepted only after it
  // has differed from the accepted level for DEB_CNT consecutive cycles.
  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_bit;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cnt <= '0;
        r_bit <= c_IN_RST[i];
      end else if (r_s2[i] == r_bit) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DEB_LAST) begin
        r_bit <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[i] = r_bit;
  end

  // Press event: debounced key falling edge (active-low key).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key_q <= 1'b1;
    end else begin
      r_key_q <= w_deb[4];
    end
  end

  assign w_kpress = r_key_q & ~w_deb[4];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_MANUAL;
      r_code  <= 3'd0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_step_nxt  = 1'b0;
    w_timer_nxt = r_timer;
    // The step below reads r_dir, so a press coinciding with a step uses the
    // old direction while the toggle lands on the same edge.
    w_dir_nxt   = r_dir ^ w_kpress;

    case (r_state)
      S_MANUAL: begin
        w_code_nxt  = w_deb[2:0];
        w_timer_nxt = '0;
        if (w_deb[3]) begin
          w_state_nxt = S_AUTO;
        end
      end
      S_AUTO: begin
        // Leaving auto mode takes priority over a coinciding timer expiry.
        if (!w_deb[3]) begin
          w_state_nxt = S_MANUAL;
          w_timer_nxt = '0;
        end else if (r_timer == c_STEP_LAST) begin
          w_timer_nxt = '0;
          w_step_nxt  = 1'b1;
          w_code_nxt  = r_dir ? (r_code - 3'd1) : (r_code + 3'd1);
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_MANUAL;
      end
    endcase
  end

  assign CODE = r_code;
  assign DIR  = r_dir;
  assign STEP = r_step;
  assign AUTO = (r_state == S_AUTO);

endmodule
`default_nettype wire
